uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, oversampled at CLKS_PER_BIT clocks
// per bit, with a two-flop input synchronizer, start-bit glitch rejection,
// framing/overrun detection and a valid/ready byte handshake.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int unsigned HALF       = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] CNT_MAX    = 16'(CLKS_PER_BIT - 1);
  // Loaded at detection so the counter reaches CNT_MAX exactly at offset HALF;
  // every later sample then falls a whole bit period after the previous one.
  localparam logic [15:0] START_LOAD = 16'(CLKS_PER_BIT - HALF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_next;
  logic        rx_meta, rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        tick;
  logic        stop_sample;
  logic        deliver;
  logic        ferr_evt;
`ifdef UART_RX_PARITY_EN
  logic        par_bit;
  logic        perr_evt;
  logic        parity_err_r;
`endif

  // Two-flop synchronizer; the line idles high, so reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; all sample points are marked by tick.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!rx_s) state_next = (HALF == 0) ? S_DATA : S_START;
      S_START: if (tick) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick) state_next = S_STOP;
`endif
      S_STOP:  if (tick) state_next = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: busy and the stop-edge events feeding the output registers.
  always_comb begin
    tick        = (cnt == CNT_MAX);
    busy        = (state != S_IDLE);
    stop_sample = (state == S_STOP) && tick;
    ferr_evt    = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
    perr_evt    = stop_sample && rx_s && (^{shift, par_bit});
    deliver     = stop_sample && rx_s && !(^{shift, par_bit});
`else
    deliver     = stop_sample && rx_s;
`endif
  end

  // Sample counter, bit counter and data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt     <= (!rx_s && (HALF != 0)) ? START_LOAD : '0;
          bit_cnt <= '0;
        end
        S_BREAK: cnt <= '0;
        default: cnt <= tick ? '0 : cnt + 16'd1;
      endcase
      if ((state == S_DATA) && tick) begin
        shift[bit_cnt] <= rx_s;
        bit_cnt        <= bit_cnt + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if ((state == S_PARITY) && tick) par_bit <= rx_s;
`endif
    end
  end

  // Handshake and error pulses; a simultaneous accept and delivery keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_evt;
      overrun   <= deliver && valid && !ready;
      if (deliver && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error pulse register.
  always_ff @(posedge clk) begin
    if (reset) parity_err_r <= 1'b0;
    else       parity_err_r <= perr_evt;
  end
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: one instance at 16 clocks per bit,
// one at 1 clock per bit (transmitter-rate stream).
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // First low capture to valid: 2 sync edges + HALF + (NBITS-1) bit periods.
  localparam int LAT16 = 2 + 7 + (NBITS - 1) * 16;
  localparam int LAT1  = 2 + 0 + (NBITS - 1);

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       rst16, rx16, rdy16, v16, busy16, fe16, pe16, ov16;
  logic [7:0] d16;
  logic       rst1, rx1, rdy1, v1, busy1, fe1, pe1, ov1;
  logic [7:0] d1;

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .reset(rst16), .rx(rx16), .data(d16), .valid(v16), .ready(rdy16),
    .busy(busy16), .frame_err(fe16), .parity_err(pe16), .overrun(ov16)
  );

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(rst1), .rx(rx1), .data(d1), .valid(v1), .ready(rdy1),
    .busy(busy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitors, sampled on the falling edge; cyc is the edge that produced the value.
  logic       v16_q = 1'b0, b16_q = 1'b0, v1_q = 1'b0;
  int         n_rise16 = 0, rise16_cyc = 0, bfall16_cyc = 0;
  logic [7:0] rise16_dat = '0;
  int         n_fe16 = 0, n_ov16 = 0, n_pe16 = 0, ov16_cyc = 0;
  int         n_rise1 = 0, n_err1 = 0;
  int         rise1_cyc [16];
  logic [7:0] rise1_dat [16];

  always @(negedge clk) begin
    v16_q <= v16;
    b16_q <= busy16;
    v1_q  <= v1;
    if (v16 && !v16_q) begin
      n_rise16   <= n_rise16 + 1;
      rise16_cyc <= cyc;
      rise16_dat <= d16;
    end
    if (!busy16 && b16_q) bfall16_cyc <= cyc;
    if (fe16) n_fe16 <= n_fe16 + 1;
    if (pe16) n_pe16 <= n_pe16 + 1;
    if (ov16) begin
      n_ov16   <= n_ov16 + 1;
      ov16_cyc <= cyc;
    end
    if (v1 && !v1_q) begin
      rise1_cyc[n_rise1[3:0]] <= cyc;
      rise1_dat[n_rise1[3:0]] <= d1;
      n_rise1 <= n_rise1 + 1;
    end
    if (fe1 || pe1 || ov1) n_err1 <= n_err1 + 1;
  end

  task automatic drive16(input logic b, input int n);
    rx16 = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns t0 = edge at which the first synchronizer flop captures the start bit.
  task automatic send16(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                        output int t0);
    t0 = cyc + 1;
    drive16(1'b0, 16);
    for (int i = 0; i < 8; i++) drive16(b[i], 16);
    if (NBITS == 11) drive16(par_bit, 16);
    drive16(stop_bit, 16);
  endtask

  task automatic drive1(input logic b);
    rx1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic frame1(input logic [7:0] b);
    drive1(1'b0);
    for (int i = 0; i < 8; i++) drive1(b[i]);
    if (NBITS == 11) drive1(^b);
    drive1(1'b1);
  endtask

  task automatic test_reset();
    rst16 = 1'b1; rst1 = 1'b1; rx16 = 1'b1; rx1 = 1'b1; rdy16 = 1'b0; rdy1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (d16 !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", d16); end
    checks++; if (v16 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy16); end
    checks++; if ({fe16, pe16, ov16} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {fe16, pe16, ov16}); end
    checks++; if ({v1, busy1, d1} !== 10'd0) begin errors++; $display("FAIL reset_dut1 got %h exp 000", {v1, busy1, d1}); end
    rst16 = 1'b0; rst1 = 1'b0;
    drive16(1'b1, 4);
  endtask

  task automatic test_nominal();
    int t0, n0, e0;
    rdy16 = 1'b1;
    n0 = n_rise16; e0 = n_fe16 + n_ov16 + n_pe16;
    send16(8'hA5, 1'b1, 1'b0, t0);
    drive16(1'b1, 8);
    checks++; if (n_rise16 - n0 !== 1) begin errors++; $display("FAIL nominal_count got %0d exp 1", n_rise16 - n0); end
    checks++; if (rise16_dat !== 8'hA5) begin errors++; $display("FAIL nominal_data got %h exp a5", rise16_dat); end
    checks++; if (rise16_cyc - t0 !== LAT16) begin errors++; $display("FAIL nominal_latency got %0d exp %0d", rise16_cyc - t0, LAT16); end
    checks++; if (bfall16_cyc - t0 !== LAT16) begin errors++; $display("FAIL nominal_busy_fall got %0d exp %0d", bfall16_cyc - t0, LAT16); end
    checks++; if (n_fe16 + n_ov16 + n_pe16 - e0 !== 0) begin errors++; $display("FAIL nominal_errs got %0d exp 0", n_fe16 + n_ov16 + n_pe16 - e0); end
    checks++; if (v16 !== 1'b0) begin errors++; $display("FAIL nominal_accept got %b exp 0", v16); end
  endtask

  task automatic test_glitch();
    int t0, n0, e0;
    n0 = n_rise16; e0 = n_fe16 + n_ov16 + n_pe16;
    drive16(1'b0, 3);
    drive16(1'b1, 40);
    checks++; if (n_rise16 - n0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", n_rise16 - n0); end
    checks++; if (n_fe16 + n_ov16 + n_pe16 - e0 !== 0) begin errors++; $display("FAIL glitch_errs got %0d exp 0", n_fe16 + n_ov16 + n_pe16 - e0); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy16); end
    send16(8'h55, 1'b1, 1'b0, t0);
    drive16(1'b1, 8);
    checks++; if (rise16_dat !== 8'h55 || n_rise16 - n0 !== 1) begin errors++; $display("FAIL glitch_next got %h/%0d exp 55/1", rise16_dat, n_rise16 - n0); end
    checks++; if (rise16_cyc - t0 !== LAT16) begin errors++; $display("FAIL glitch_latency got %0d exp %0d", rise16_cyc - t0, LAT16); end
  endtask

  task automatic test_framing();
    int t0, n0, f0;
    n0 = n_rise16; f0 = n_fe16;
    send16(8'h12, 1'b0, 1'b0, t0);
    drive16(1'b0, 100);
    checks++; if (n_fe16 - f0 !== 1) begin errors++; $display("FAIL frame_count got %0d exp 1", n_fe16 - f0); end
    checks++; if (n_rise16 - n0 !== 0 || v16 !== 1'b0) begin errors++; $display("FAIL frame_valid got %0d/%b exp 0/0", n_rise16 - n0, v16); end
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL frame_break_busy got %b exp 1", busy16); end
    drive16(1'b1, 20);
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL frame_break_exit got %b exp 0", busy16); end
    send16(8'h34, 1'b1, 1'b1, t0);
    drive16(1'b1, 8);
    checks++; if (rise16_dat !== 8'h34 || n_rise16 - n0 !== 1) begin errors++; $display("FAIL frame_next got %h/%0d exp 34/1", rise16_dat, n_rise16 - n0); end
  endtask

  task automatic test_overrun();
    int ta, tb, n0, o0;
    rdy16 = 1'b0;
    n0 = n_rise16; o0 = n_ov16;
    send16(8'h11, 1'b1, 1'b0, ta);
    drive16(1'b1, 5);
    send16(8'h22, 1'b1, 1'b0, tb);
    drive16(1'b1, 5);
    checks++; if (n_ov16 - o0 !== 1) begin errors++; $display("FAIL overrun_count got %0d exp 1", n_ov16 - o0); end
    checks++; if (ov16_cyc - tb !== LAT16) begin errors++; $display("FAIL overrun_edge got %0d exp %0d", ov16_cyc - tb, LAT16); end
    checks++; if (d16 !== 8'h11 || v16 !== 1'b1) begin errors++; $display("FAIL overrun_hold got %h/%b exp 11/1", d16, v16); end
    checks++; if (n_rise16 - n0 !== 1) begin errors++; $display("FAIL overrun_rises got %0d exp 1", n_rise16 - n0); end
    rdy16 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (v16 !== 1'b0) begin errors++; $display("FAIL overrun_accept got %b exp 0", v16); end
  endtask

  task automatic test_reset_midframe();
    int t0, n0, f0;
    n0 = n_rise16; f0 = n_fe16;
    // Start bit plus bits 0..3 of 0x00, then halfway into bit 4.
    drive16(1'b0, 16 + 4 * 16 + 8);
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL midframe_busy_before got %b exp 1", busy16); end
    rst16 = 1'b1;
    rx16 = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (d16 !== 8'h00 || v16 !== 1'b0 || busy16 !== 1'b0) begin errors++; $display("FAIL midframe_reset got %h/%b/%b exp 00/0/0", d16, v16, busy16); end
    checks++; if ({fe16, pe16, ov16} !== 3'b000) begin errors++; $display("FAIL midframe_pulses got %b exp 000", {fe16, pe16, ov16}); end
    rst16 = 1'b0;
    drive16(1'b1, 20);
    checks++; if (n_fe16 - f0 !== 0 || n_rise16 - n0 !== 0) begin errors++; $display("FAIL midframe_quiet got %0d/%0d exp 0/0", n_fe16 - f0, n_rise16 - n0); end
    send16(8'h77, 1'b1, 1'b0, t0);
    drive16(1'b1, 8);
    checks++; if (rise16_dat !== 8'h77 || rise16_cyc - t0 !== LAT16) begin errors++; $display("FAIL midframe_next got %h/%0d exp 77/%0d", rise16_dat, rise16_cyc - t0, LAT16); end
  endtask

  task automatic test_back_to_back();
    int ta, tb, n0, e0;
    rdy1 = 1'b1;
    n0 = n_rise1; e0 = n_err1;
    ta = cyc + 1;
    frame1(8'h3C);
    tb = cyc + 1;
    frame1(8'h81);
    repeat (20) drive1(1'b1);
    checks++; if (n_rise1 - n0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", n_rise1 - n0); end
    checks++; if (rise1_dat[n0] !== 8'h3C || rise1_cyc[n0] - ta !== LAT1) begin errors++; $display("FAIL b2b_first got %h/%0d exp 3c/%0d", rise1_dat[n0], rise1_cyc[n0] - ta, LAT1); end
    checks++; if (rise1_dat[n0+1] !== 8'h81 || rise1_cyc[n0+1] - tb !== LAT1) begin errors++; $display("FAIL b2b_second got %h/%0d exp 81/%0d", rise1_dat[n0+1], rise1_cyc[n0+1] - tb, LAT1); end
    checks++; if (n_err1 - e0 !== 0) begin errors++; $display("FAIL b2b_errs got %0d exp 0", n_err1 - e0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int t0, n0, p0;
    n0 = n_rise16; p0 = n_pe16;
    send16(8'h07, 1'b1, 1'b1, t0);
    drive16(1'b1, 8);
    checks++; if (rise16_dat !== 8'h07 || n_rise16 - n0 !== 1 || n_pe16 - p0 !== 0) begin errors++; $display("FAIL parity_good got %h/%0d/%0d exp 07/1/0", rise16_dat, n_rise16 - n0, n_pe16 - p0); end
    send16(8'h07, 1'b1, 1'b0, t0);
    drive16(1'b1, 8);
    checks++; if (n_pe16 - p0 !== 1 || n_rise16 - n0 !== 1) begin errors++; $display("FAIL parity_bad got %0d/%0d exp 1/1", n_pe16 - p0, n_rise16 - n0); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
